// File: rtl/writeback_pipelined_pkg.sv
// Shared constants for the writeback stage: result-source selects,
// load funct3 encodings and the fixed RV32 load width.
package wb_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [1:0] RESULT_PC4  = 2'b10;
  localparam logic [1:0] RESULT_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_pipelined_load_align.sv
// Extracts a byte, halfword or word from a naturally aligned memory word
// and sign- or zero-extends it. Misaligned halfwords drop off[0]; traps
// are raised elsewhere.
module load_align
  import wb_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[8*off +: 8];
  assign half_sel = off[1] ? word[31:16] : word[15:0];

  // Select the access size and apply the extension for the funct3 code.
  always_comb begin
    // NOTE: a default assignment before the case keeps every path driven,
    // so no latch is inferred for codes the case does not list.
    value = word;
    case (funct3)
      F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  value = {24'b0, byte_sel};
      F3_LH:   value = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  value = {16'b0, half_sel};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/writeback_pipelined.sv
// MEM/WB pipeline register with stall and flush, result selection, load
// alignment, x0 write suppression and per-thread retire counters for the
// barrel RISC-V core.
module writeback_pipelined
  import wb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_THREADS   = 8,
  parameter int BITS_THREADS  = $clog2(NUM_THREADS),
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_m,
  input  logic                     stall_w,
  input  logic                     flush_w,
  input  logic                     reg_write_m,
  input  logic [1:0]               result_src_m,
  input  logic [2:0]               funct3_m,
  input  logic [DATA_WIDTH-1:0]    alu_result_m,
  input  logic [DATA_WIDTH-1:0]    read_data_m,
  input  logic [DATA_WIDTH-1:0]    imm_ext_m,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
  input  logic [4:0]               rd_m,
  input  logic [BITS_THREADS-1:0]  tid_m,
  output logic [DATA_WIDTH-1:0]    result_w,
  output logic                     reg_write_w,
  output logic [4:0]               rd_w,
  output logic [BITS_THREADS-1:0]  tid_w,
  output logic                     valid_w,
  input  logic [BITS_THREADS-1:0]  cnt_tid,
  output logic [COUNTER_WIDTH-1:0] cnt_value
);

  // One counter per encodable thread id, so any tid indexes in range.
  localparam int NUM_ENTRIES = 2 ** BITS_THREADS;

  logic                     valid_q;
  logic                     reg_write_q;
  logic [1:0]               src_q;
  logic [2:0]               funct3_q;
  logic [DATA_WIDTH-1:0]    alu_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic [DATA_WIDTH-1:0]    imm_q;
  logic [ADDRESS_WIDTH-1:0] pc4_q;
  logic [4:0]               rd_q;
  logic [BITS_THREADS-1:0]  tid_q;

  logic [COUNTER_WIDTH-1:0] cnt_q [NUM_ENTRIES];

  logic [DATA_WIDTH-1:0]    load_value;
  logic [DATA_WIDTH-1:0]    pc4_ext;
  logic                     retire;

  // MEM/WB register: flush squashes, stall holds, otherwise capture M.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments for all state so every register
      // samples pre-edge values regardless of statement order.
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      src_q       <= '0;
      funct3_q    <= '0;
      alu_q       <= '0;
      rdata_q     <= '0;
      imm_q       <= '0;
      pc4_q       <= '0;
      rd_q        <= '0;
      tid_q       <= '0;
    end else if (flush_w) begin
      valid_q     <= 1'b0;
    end else if (!stall_w) begin
      valid_q     <= valid_m;
      reg_write_q <= reg_write_m;
      src_q       <= result_src_m;
      funct3_q    <= funct3_m;
      alu_q       <= alu_result_m;
      rdata_q     <= read_data_m;
      imm_q       <= imm_ext_m;
      pc4_q       <= pc_plus4_m;
      rd_q        <= rd_m;
      tid_q       <= tid_m;
    end
  end

  load_align u_load_align (
    .word   (rdata_q),
    .off    (alu_q[1:0]),
    .funct3 (funct3_q),
    .value  (load_value)
  );

  // Fit the return address to the datapath width.
  generate
    if (ADDRESS_WIDTH >= DATA_WIDTH) begin : g_pc_trunc
      assign pc4_ext = pc4_q[DATA_WIDTH-1:0];
    end else begin : g_pc_zext
      assign pc4_ext = {{(DATA_WIDTH-ADDRESS_WIDTH){1'b0}}, pc4_q};
    end
  endgenerate

  // Result source mux driven from registered fields.
  always_comb begin
    result_w = alu_q;
    case (src_q)
      RESULT_ALU:  result_w = alu_q;
      RESULT_LOAD: result_w = load_value;
      RESULT_PC4:  result_w = pc4_ext;
      RESULT_IMM:  result_w = imm_q;
      default:     result_w = alu_q;
    endcase
  end

  assign reg_write_w = reg_write_q & valid_q & (rd_q != 5'd0);
  assign rd_w        = rd_q;
  assign tid_w       = tid_q;
  assign valid_w     = valid_q;

  // An instruction retires on the edge it leaves W; flush does not cancel it.
  assign retire = valid_q & ~stall_w;

  // Per-thread retire counters; only the retiring thread's entry moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this array is architecturally visible state that must read
      // zero after reset, so every entry is reset rather than left as RAM.
      for (int i = 0; i < NUM_ENTRIES; i++) cnt_q[i] <= '0;
    end else if (retire) begin
      cnt_q[tid_q] <= cnt_q[tid_q] + COUNTER_WIDTH'(1);
    end
  end

  assign cnt_value = cnt_q[cnt_tid];

endmodule
